// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
// Bundles the two handshakes that fifo_rd_stream sits between:
//   FIFO read side : rd_en (to FIFO), data_out / empty / underflow (from FIFO)
//   Stream side    : m_data / m_valid (to consumer), m_ready (from consumer)
// Modports
//   master : the read-stream block (drives rd_en, m_data, m_valid)
//   slave  : the environment, i.e. the FIFO plus the downstream consumer
// Stream handshake: a word transfers on every rising clock edge where
// m_valid && m_ready. Once m_valid is high it stays high, with m_data
// unchanged, until that transfer happens.
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
  parameter int FIFO_WIDTH = 16
);
  // FIFO read port
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  underflow;
  // Downstream stream port
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output rd_en,
    input  data_out,
    input  empty,
    input  underflow,
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  rd_en,
    output data_out,
    output empty,
    output underflow,
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side master for the synchronous FIFO. Issues rd_en, captures data_out
// one cycle later (registered FIFO read latency), and re-presents each word on
// a valid/ready stream through a 2-entry skid buffer so back-pressure never
// loses or duplicates a word.
//
// Ports
//   i_clk           : clock, all state on the rising edge
//   i_rst           : asynchronous, active-high reset
//   i_enable        : permits new FIFO reads
//   i_clr_err       : synchronous clear of o_underflow_err (set wins)
//   bus             : fifo_rd_stream_if.master (FIFO read port + stream port)
//   o_rd_count      : words delivered on the stream, wraps modulo 2^CNT_WIDTH
//   o_underflow_err : sticky, set by the FIFO underflow pulse
//   o_dbg_cnt       : skid-buffer occupancy (0..2)
//   o_dbg_inflight  : a read was issued last cycle and its data is on data_out
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_clr_err,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] o_rd_count,
  output logic                 o_underflow_err,
  output logic [1:0]           o_dbg_cnt,
  output logic                 o_dbg_inflight
);

  // Skid buffer: r_buf0 is always the head presented on m_data.
  logic [FIFO_WIDTH-1:0] r_buf0;
  logic [FIFO_WIDTH-1:0] r_buf1;
  logic [1:0]            r_cnt;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_rd_count;
  logic                  r_underflow_err;

  logic [FIFO_WIDTH-1:0] w_buf0_nxt;
  logic [FIFO_WIDTH-1:0] w_buf1_nxt;
  logic [1:0]            w_cnt_nxt;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_cap;
  logic [2:0]            w_level;
  logic                  w_rd_en;

  assign w_valid = (r_cnt != 2'd0);
  assign w_pop   = w_valid && bus.m_ready;
  assign w_cap   = r_inflight;

  // Occupancy the buffer will have once the word already in flight lands and
  // this cycle's pop leaves. A new read is only safe if that leaves a free
  // slot for the word it will bring back next cycle. Same-cycle pop counts,
  // which is what keeps full throughput with m_ready held high.
  assign w_level = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Forced low while reset is held, independent of the registered state.
  assign w_rd_en = !i_rst && i_enable && !bus.empty && (w_level < 3'd2);

  // Buffer update. The captured word always goes to the tail after any shift.
  always_comb begin
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    w_cnt_nxt  = r_cnt;
    case ({w_cap, w_pop})
      2'b10: begin
        if (r_cnt == 2'd0) begin
          w_buf0_nxt = bus.data_out;
        end else begin
          w_buf1_nxt = bus.data_out;
        end
        w_cnt_nxt = r_cnt + 2'd1;
      end
      2'b01: begin
        w_buf0_nxt = r_buf1;
        w_cnt_nxt  = r_cnt - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; head leaves, captured word joins the tail.
        if (r_cnt == 2'd2) begin
          w_buf0_nxt = r_buf1;
          w_buf1_nxt = bus.data_out;
        end else begin
          w_buf0_nxt = bus.data_out;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      // The read-issue rule must make a third buffered word impossible.
      assert (({1'b0, r_cnt} + {2'b00, w_cap} - {2'b00, w_pop}) <= 3'd2);
      r_buf0     <= w_buf0_nxt;
      r_buf1     <= w_buf1_nxt;
      r_cnt      <= w_cnt_nxt;
      r_inflight <= w_rd_en;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_count <= '0;
    end else if (w_pop) begin
      r_rd_count <= r_rd_count + 1'b1;
    end
  end

  // Set has priority over clear so a pulse coinciding with clr_err is kept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_underflow_err <= 1'b0;
    end else if (bus.underflow) begin
      r_underflow_err <= 1'b1;
    end else if (i_clr_err) begin
      r_underflow_err <= 1'b0;
    end
  end

  assign bus.rd_en       = w_rd_en;
  assign bus.m_data      = r_buf0;
  assign bus.m_valid     = w_valid;
  assign o_rd_count      = r_rd_count;
  assign o_underflow_err = r_underflow_err;
  assign o_dbg_cnt       = r_cnt;
  assign o_dbg_inflight  = r_inflight;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream. A small FIFO model holding 0x0001..0x0008
// answers rd_en with one cycle of latency; a monitor logs delivered words and
// rd_en pulses. Inputs change on the falling edge, outputs are checked 1 ns
// after it.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;
  localparam int W = 16;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clr_err;
  logic [15:0] rd_count;
  logic        underflow_err;
  logic [1:0]  dbg_cnt;
  logic        dbg_inflight;

  fifo_rd_stream_if #(.FIFO_WIDTH(W)) bus ();

  fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_clr_err       (clr_err),
    .bus             (bus.master),
    .o_rd_count      (rd_count),
    .o_underflow_err (underflow_err),
    .o_dbg_cnt       (dbg_cnt),
    .o_dbg_inflight  (dbg_inflight)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  // rd_ptr == 8 means empty; fifo_clr refills with words 1..8.
  int   rd_ptr = 8;
  logic fifo_clr;

  assign bus.empty = (rd_ptr >= 8);

  initial bus.data_out = '0;
  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= 0;
    end else if (bus.rd_en) begin
      bus.data_out <= 16'(rd_ptr + 1);
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int           rd_en_cnt;

  always @(posedge clk) begin
    if (rst) begin
      got_q.delete();
      rd_en_cnt <= 0;
    end else begin
      if (bus.rd_en) rd_en_cnt <= rd_en_cnt + 1;
      if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares the delivered-word log with the consecutive words first..last.
  task automatic check_got(input string tag, input int first, input int last);
    exp_q.delete();
    for (int v = first; v <= last; v++) exp_q.push_back(W'(v));
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Resets the DUT and refills the FIFO; returns on the release edge.
  task automatic start_test();
    @(negedge clk);
    rst           = 1'b1;
    fifo_clr      = 1'b1;
    enable        = 1'b0;
    bus.m_ready   = 1'b0;
    bus.underflow = 1'b0;
    clr_err       = 1'b0;
    tick(2);
    rst      = 1'b0;
    fifo_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b0;
    fifo_clr      = 1'b0;
    enable        = 1'b0;
    clr_err       = 1'b0;
    bus.m_ready   = 1'b0;
    bus.underflow = 1'b0;

    // Reset asserted between clock edges takes effect at once.
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_uf_err", underflow_err, 0);
    chk("rst_dbg_cnt", dbg_cnt, 0);

    // Streaming with m_ready held high.
    start_test();
    enable      = 1'b1;
    bus.m_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      #1;
      chk("stream_rd_en", bus.rd_en, (k <= 7));
      chk("stream_m_valid", bus.m_valid, (k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) chk("stream_m_data", bus.m_data, k - 1);
      @(negedge clk);
    end
    chk("stream_rd_count", rd_count, 8);
    chk("stream_rd_en_pulses", rd_en_cnt, 8);
    check_got("stream", 1, 8);

    // Back-pressure: only two reads ahead, head held stable.
    start_test();
    enable      = 1'b1;
    bus.m_ready = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      #1;
      chk("bp_rd_en", bus.rd_en, (k <= 1));
      if (k >= 2) begin
        chk("bp_m_valid", bus.m_valid, 1);
        chk("bp_m_data", bus.m_data, 16'h0001);
      end
      @(negedge clk);
    end
    chk("bp_rd_en_pulses", rd_en_cnt, 2);
    chk("bp_occupancy", dbg_cnt, 2);
    chk("bp_rd_count_hold", rd_count, 0);
    bus.m_ready = 1'b1;
    tick(15);
    chk("bp_rd_count", rd_count, 8);
    chk("bp_rd_en_total", rd_en_cnt, 8);
    check_got("bp", 1, 8);

    // Enable drop after the third read.
    start_test();
    enable      = 1'b1;
    bus.m_ready = 1'b1;
    tick(3);
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("endrop_rd_en", bus.rd_en, 0);
      @(negedge clk);
    end
    chk("endrop_rd_en_pulses", rd_en_cnt, 3);
    chk("endrop_rd_count", rd_count, 3);
    chk("endrop_m_valid", bus.m_valid, 0);
    check_got("endrop", 1, 3);
    enable = 1'b1;
    #1;
    chk("reen_rd_en", bus.rd_en, 1);
    tick(12);
    chk("reen_rd_count", rd_count, 8);
    check_got("reen", 1, 8);

    // Sticky underflow error, set wins over clear.
    start_test();
    #1;
    chk("uf_initial", underflow_err, 0);
    @(negedge clk);
    bus.underflow = 1'b1;
    @(negedge clk);
    bus.underflow = 1'b0;
    #1;
    chk("uf_set", underflow_err, 1);
    tick(3);
    #1;
    chk("uf_sticky", underflow_err, 1);
    @(negedge clk);
    bus.underflow = 1'b1;
    clr_err       = 1'b1;
    @(negedge clk);
    bus.underflow = 1'b0;
    clr_err       = 1'b0;
    #1;
    chk("uf_set_priority", underflow_err, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    chk("uf_cleared", underflow_err, 0);

    // Reset mid-stream: words 3 (buffered) and 4 (in flight) are discarded.
    start_test();
    enable      = 1'b1;
    bus.m_ready = 1'b1;
    tick(4);
    chk("mid_pre_rd_count", rd_count, 2);
    chk("mid_pre_cnt", dbg_cnt, 1);
    chk("mid_pre_inflight", dbg_inflight, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_rd_en", bus.rd_en, 0);
    chk("mid_rst_rd_count", rd_count, 0);
    chk("mid_rst_m_data", bus.m_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_m_valid", bus.m_valid, 0);
    chk("mid_rel_rd_count", rd_count, 0);
    chk("mid_rel_inflight", dbg_inflight, 0);
    tick(12);
    chk("mid_rd_count", rd_count, 4);
    check_got("mid", 5, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
